// File: rtl/card_pkg.sv
// Shared card types and the 13-to-1 rank wrap used by both the rank counter and the search pointer.
package card_pkg;

  typedef logic [3:0] rank_t;

  localparam rank_t RANK_MIN       = 4'd1;
  localparam rank_t RANK_MAX       = 4'd13;
  localparam int    CARDS_PER_RANK = 4;
  localparam int    CARDS_PER_DECK = 52;

  typedef logic [0:0] state_t;
  localparam state_t IDLE   = 1'b0;
  localparam state_t SEARCH = 1'b1;

  function automatic rank_t next_rank(input rank_t r);
    return (r == RANK_MAX) ? RANK_MIN : r + 4'd1;
  endfunction

endpackage

// File: rtl/card_shoe_if.sv
// Request/response bundle between the baccarat controller (master) and the card shoe (slave).
interface card_shoe_if #(
  parameter int NUM_DECKS = 1,
  parameter int CL_W      = $clog2(52*NUM_DECKS+1)
);
  import card_pkg::*;

  logic            deal_req;
  logic            shuffle_req;
  rank_t           card_value;
  logic            card_valid;
  logic            busy;
  logic            deal_err;
  logic            empty;
  logic [CL_W-1:0] cards_left;

  modport master (
    output deal_req, shuffle_req,
    input  card_value, card_valid, busy, deal_err, empty, cards_left
  );

  modport slave (
    input  deal_req, shuffle_req,
    output card_value, card_valid, busy, deal_err, empty, cards_left
  );
endinterface

// File: rtl/rank_counter.sv
// Free-running 1..13 rank counter; advances every edge and never stalls.
module rank_counter
  import card_pkg::*;
(
  input  logic  CLOCK_50,
  input  logic  reset,
  output rank_t rank
);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) rank <= RANK_MIN;
    else       rank <= next_rank(rank);
  end

endmodule

// File: rtl/card_shoe.sv
// Finite shoe dealing ranks without replacement: random start from the rank counter, then one rank scanned per edge.
// Deal latency 2..14 edges; requests while busy are dropped, requests on an empty shoe pulse deal_err.
module card_shoe
  import card_pkg::*;
#(
  parameter int NUM_DECKS = 1
) (
  input  logic      CLOCK_50,
  input  logic      reset,
  card_shoe_if.slave shoe
);

  localparam int CNT_W = $clog2(CARDS_PER_RANK*NUM_DECKS+1);
  localparam int CL_W  = $clog2(CARDS_PER_DECK*NUM_DECKS+1);
  localparam logic [CNT_W-1:0] FULL_RANK = CNT_W'(CARDS_PER_RANK*NUM_DECKS);
  localparam logic [CL_W-1:0]  FULL_SHOE = CL_W'(CARDS_PER_DECK*NUM_DECKS);

  rank_t            rank;
  rank_t            ptr;
  state_t           state;
  logic [CNT_W-1:0] counts [1:13];
  logic [CL_W-1:0]  cards_left;
  rank_t            card_value;
  logic             card_valid;
  logic             busy;
  logic             deal_err;

  rank_counter u_rank_counter (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .rank     (rank)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 1; i <= 13; i++) counts[i] <= FULL_RANK;
      cards_left <= FULL_SHOE;
      card_value <= '0;
      card_valid <= 1'b0;
      busy       <= 1'b0;
      deal_err   <= 1'b0;
      ptr        <= RANK_MIN;
      state      <= IDLE;
    end else begin
      card_valid <= 1'b0;
      deal_err   <= 1'b0;
      // Shuffle wins in either state and aborts any search in flight.
      if (shoe.shuffle_req) begin
        for (int i = 1; i <= 13; i++) counts[i] <= FULL_RANK;
        cards_left <= FULL_SHOE;
        busy       <= 1'b0;
        state      <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (shoe.deal_req) begin
              if (cards_left == '0) begin
                deal_err <= 1'b1;
              end else begin
                ptr   <= rank;
                busy  <= 1'b1;
                state <= SEARCH;
              end
            end
          end
          SEARCH: begin
            if (counts[ptr] != '0) begin
              counts[ptr] <= counts[ptr] - CNT_W'(1);
              cards_left  <= cards_left - CL_W'(1);
              card_value  <= ptr;
              card_valid  <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end else begin
              ptr <= next_rank(ptr);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign shoe.card_value = card_value;
  assign shoe.card_valid = card_valid;
  assign shoe.busy       = busy;
  assign shoe.deal_err   = deal_err;
  assign shoe.cards_left = cards_left;
  assign shoe.empty      = (cards_left == '0);

endmodule
